// File: rtl/cam_pkg.sv
// Shared camera-capture types and default frame-buffer geometry.
// Used by the capture writer and by the display path that reads the same buffer.
package cam_pkg;

  localparam int CAM_SRC_W  = 640;
  localparam int CAM_SRC_H  = 480;
  localparam int CAM_X_SIZE = 128;
  localparam int CAM_Y_SIZE = 128;
  localparam int CAM_STEP_X = 5;
  localparam int CAM_STEP_Y = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ACTIVE,
    DONE
  } cam_state_t;

  typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/cam_bus_sync.sv
// OV7670 bus synchronizer: 2-flop sync of vsync/href/pclk/d, pclk rising-edge strobe with sampled byte.
// Three clk of latency from the pin to strobe/data; no backpressure, one strobe per pclk rise.
module cam_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic       cam_pclk,
  input  logic [7:0] cam_d,
  output logic       vsync,
  output logic       href,
  output logic       strobe,
  output logic [7:0] data
);

  logic [1:0] vsync_sync;
  logic [1:0] href_sync;
  logic [1:0] pclk_sync;
  logic       pclk_prev;
  logic [7:0] d_meta;
  logic [7:0] d_sync;
  logic       pclk_rise;

  assign pclk_rise = pclk_sync[1] & ~pclk_prev;

  // vsync/href leave through the same register stage as strobe so edges stay aligned with bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_sync <= '0;
      href_sync  <= '0;
      pclk_sync  <= '0;
      pclk_prev  <= 1'b0;
      d_meta     <= '0;
      d_sync     <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      strobe     <= 1'b0;
      data       <= '0;
    end else begin
      vsync_sync <= {vsync_sync[0], cam_vsync};
      href_sync  <= {href_sync[0], cam_href};
      pclk_sync  <= {pclk_sync[0], cam_pclk};
      pclk_prev  <= pclk_sync[1];
      d_meta     <= cam_d;
      d_sync     <= d_meta;
      vsync      <= vsync_sync[1];
      href       <= href_sync[1];
      strobe     <= pclk_rise;
      if (pclk_rise) data <= d_sync;
    end
  end

endmodule

// File: rtl/cam_frame_writer.sv
// Camera capture writer: assembles RGB565 pixels, decimates to the buffer window, one write per kept pixel.
// wr_en 4 clk after the second byte's pclk is sampled high; buffer has no backpressure.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int c_src_w  = CAM_SRC_W,
  parameter int c_src_h  = CAM_SRC_H,
  parameter int c_x_size = CAM_X_SIZE,
  parameter int c_y_size = CAM_Y_SIZE,
  parameter int c_step_x = CAM_STEP_X,
  parameter int c_step_y = CAM_STEP_Y
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_pclk,
  input  logic [7:0]  cam_d,
  output logic        wr_en,
  output logic [6:0]  wr_col,
  output logic [6:0]  wr_row,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        short_frame
);

  localparam logic [9:0] SRC_W  = 10'(c_src_w);
  localparam logic [9:0] SRC_H  = 10'(c_src_h);
  localparam logic [7:0] X_SIZE = 8'(c_x_size);
  localparam logic [7:0] Y_SIZE = 8'(c_y_size);
  localparam logic [7:0] STEP_X = 8'(c_step_x);
  localparam logic [7:0] STEP_Y = 8'(c_step_y);

  cam_state_t state, state_nx;

  logic       vsync, href, strobe;
  logic [7:0] data;
  logic       vsync_q, href_q;
  logic       vs_rise, vs_fall, hr_rise, hr_fall;

  logic       phase;
  logic [7:0] byte_hi;
  logic [9:0] src_x, src_y;
  logic [7:0] x_step, y_step;
  logic [7:0] col, row;
  logic       line_keep;
  logic       pix_done, keep, last_pix;

  logic       pend_vld;
  logic [6:0] pend_col, pend_row;
  rgb565_t    pend_dat;
  logic       busy_d, done_d;

  cam_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_pclk  (cam_pclk),
    .cam_d     (cam_d),
    .vsync     (vsync),
    .href      (href),
    .strobe    (strobe),
    .data      (data)
  );

  assign vs_rise  = vsync & ~vsync_q;
  assign vs_fall  = ~vsync & vsync_q;
  assign hr_rise  = href & ~href_q;
  assign hr_fall  = ~href & href_q;
  assign pix_done = (state == ACTIVE) && href && strobe && phase;
  assign keep     = line_keep && (x_step == 8'd0) && (col < X_SIZE) &&
                    (row < Y_SIZE) && (src_x < SRC_W);
  assign last_pix = pix_done && keep && (col == X_SIZE - 8'd1) && (row == Y_SIZE - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (enable) state_nx = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) state_nx = enable ? ACTIVE : IDLE;
      ACTIVE:     if (vs_rise || last_pix) state_nx = DONE;
      DONE:       state_nx = WAIT_FRAME;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state == ACTIVE);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      byte_hi     <= '0;
      src_x       <= '0;
      src_y       <= '0;
      x_step      <= '0;
      y_step      <= '0;
      col         <= '0;
      row         <= '0;
      line_keep   <= 1'b0;
      pend_vld    <= 1'b0;
      pend_col    <= '0;
      pend_row    <= '0;
      pend_dat    <= '0;
      short_frame <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      href_q   <= href;
      pend_vld <= 1'b0;
      if (state == WAIT_FRAME && vs_fall) begin
        phase       <= 1'b0;
        src_x       <= '0;
        src_y       <= '0;
        x_step      <= '0;
        y_step      <= '0;
        col         <= '0;
        row         <= '0;
        line_keep   <= 1'b0;
        short_frame <= 1'b0;
      end else if (state == ACTIVE) begin
        if (vs_rise && row < Y_SIZE) short_frame <= 1'b1;
        // a dangling odd byte dies here because phase is forced back to 0 outside href
        if (!href) begin
          phase <= 1'b0;
        end else if (strobe) begin
          phase <= ~phase;
          if (!phase) begin
            byte_hi <= data;
          end else begin
            pend_vld <= keep;
            pend_dat <= {byte_hi, data};
            pend_col <= col[6:0];
            pend_row <= row[6:0];
            if (src_x != SRC_W) src_x <= src_x + 10'd1;
            x_step <= (x_step == STEP_X - 8'd1) ? 8'd0 : x_step + 8'd1;
            if (keep) col <= col + 8'd1;
          end
        end
        if (hr_rise) begin
          line_keep <= (y_step == 8'd0) && (src_y < SRC_H);
          src_x     <= '0;
          x_step    <= '0;
        end
        if (hr_fall) begin
          if (line_keep) begin
            if (row != Y_SIZE) row <= row + 8'd1;
            col <= '0;
          end
          y_step <= (y_step == STEP_Y - 8'd1) ? 8'd0 : y_step + 8'd1;
          if (src_y != SRC_H) src_y <= src_y + 10'd1;
        end
      end
    end
  end

  // write port updates regardless of state so the final pixel still lands after DONE is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_col     <= '0;
      wr_row     <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= pend_vld;
      busy       <= busy_d;
      frame_done <= done_d;
      if (pend_vld) begin
        wr_col  <= pend_col;
        wr_row  <= pend_row;
        wr_data <= pend_dat;
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench for cam_frame_writer on a 16x16 source, 4x4 window, steps 3 (columns) x 2 (lines).
// Stimulus pushes expected writes (row, col, data, cycle); a negedge monitor pops and compares.
module tb_cam_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic        cam_pclk = 1'b0;
  logic [7:0]  cam_d = '0;
  logic        wr_en;
  logic [6:0]  wr_col, wr_row;
  logic [15:0] wr_data;
  logic        busy, frame_done, short_frame;

  typedef struct {
    int          row;
    int          col;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   last_row = -1;
  logic busy_start, sf_start;

  cam_frame_writer #(
    .c_src_w(16), .c_src_h(16), .c_x_size(4), .c_y_size(4), .c_step_x(3), .c_step_y(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk), .cam_d(cam_d),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .short_frame(short_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && frame_done) done_cnt++;
    if (rst_n && wr_en) begin
      exp_t e;
      n_chk++;
      wr_cnt++;
      last_row = int'(wr_row);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got row %0d col %0d data %h at cycle %0d, required no write",
                 wr_row, wr_col, wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(wr_row) != e.row || int'(wr_col) != e.col || wr_data != e.dat || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL write: got row %0d col %0d data %h cycle %0d, required row %0d col %0d data %h cycle %0d",
                   wr_row, wr_col, wr_data, cyc, e.row, e.col, e.dat, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pixel p of line L is written iff line and column fall on a step and inside the 4x4 window
  function automatic bit kept(input int L, input int p);
    return (L % 2 == 0) && (L / 2 < 4) && (p % 3 == 0) && (p / 3 < 4);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit push, input exp_t e);
    exp_t x;
    cam_d = b;
    wait_clk(2);
    cam_pclk = 1'b1;
    x = e;
    x.cyc = cyc + 5;
    if (push) exp_q.push_back(x);
    wait_clk(4);
    cam_pclk = 1'b0;
    wait_clk(2);
  endtask

  // mode 0: F8,00,07,E0 repeating; mode 1: byte pair {pixel index, line index}
  task automatic send_line(input int L, input int nbytes, input int mode, input bit exp_on);
    logic [7:0] pat [4];
    pat[0] = 8'hF8; pat[1] = 8'h00; pat[2] = 8'h07; pat[3] = 8'hE0;
    cam_href = 1'b1;
    wait_clk(4);
    for (int b = 0; b < nbytes; b++) begin
      int p;
      logic [7:0] bv;
      exp_t e;
      p = b / 2;
      if (mode == 0) bv = pat[b % 4];
      else           bv = (b % 2 == 0) ? 8'(p) : 8'(L);
      e.row = L / 2;
      e.col = p / 3;
      e.dat = (mode == 0) ? ((p % 2 == 0) ? 16'hF800 : 16'h07E0) : {8'(p), 8'(L)};
      e.cyc = 0;
      send_byte(bv, exp_on && (b % 2 == 1) && kept(L, p), e);
    end
    cam_href = 1'b0;
    wait_clk(8);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_col", int'(wr_col), 0);
    check("rst_wr_row", int'(wr_row), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_short_frame", int'(short_frame), 0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  task automatic run_frame(input int nlines, input int mode, input bit exp_on,
                           input int odd_line, input int drop_line, input int rst_line);
    bit e;
    e = exp_on;
    cam_vsync = 1'b0;
    wait_clk(10);
    busy_start = busy;
    sf_start   = short_frame;
    for (int L = 0; L < nlines; L++) begin
      if (L == drop_line) enable = 1'b0;
      if (L == rst_line) begin
        reset_pulse();
        e = 1'b0;
      end
      send_line(L, (L == odd_line) ? 7 : 32, mode, e);
    end
    cam_vsync = 1'b1;
    wait_clk(12);
  endtask

  int w0, d0;

  initial begin
    wait_clk(3);
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_wr_col", int'(wr_col), 0);
    check("reset_wr_row", int'(wr_row), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_short_frame", int'(short_frame), 0);
    rst_n = 1'b1;
    wait_clk(3);
    enable = 1'b1;
    wait_clk(4);
    check("busy_waiting", int'(busy), 0);

    // full frame, data = pixel/line index
    w0 = wr_cnt; d0 = done_cnt;
    run_frame(8, 1, 1'b1, -1, -1, -1);
    check("full_writes", wr_cnt - w0, 16);
    check("full_done", done_cnt - d0, 1);
    check("full_short", int'(short_frame), 0);
    check("full_busy_active", int'(busy_start), 1);
    check("full_busy_after", int'(busy), 0);
    check("full_last_row", last_row, 3);

    // RGB565 byte pairing
    w0 = wr_cnt;
    run_frame(8, 0, 1'b1, -1, -1, -1);
    check("rgb_writes", wr_cnt - w0, 16);

    // vsync after two kept lines
    w0 = wr_cnt; d0 = done_cnt;
    run_frame(3, 1, 1'b1, -1, -1, -1);
    check("short_writes", wr_cnt - w0, 8);
    check("short_done", done_cnt - d0, 1);
    check("short_flag", int'(short_frame), 1);
    check("short_last_row", last_row, 1);

    // 7-byte first line; also confirms short_frame cleared at frame start
    w0 = wr_cnt;
    run_frame(3, 1, 1'b1, 0, -1, -1);
    check("short_cleared", int'(sf_start), 0);
    check("odd_writes", wr_cnt - w0, 5);
    check("odd_short", int'(short_frame), 1);

    // enable drops mid-frame: frame finishes, then two frames with nothing
    w0 = wr_cnt; d0 = done_cnt;
    run_frame(8, 1, 1'b1, -1, 2, -1);
    check("freeze_writes", wr_cnt - w0, 16);
    check("freeze_done", done_cnt - d0, 1);
    w0 = wr_cnt; d0 = done_cnt;
    run_frame(8, 1, 1'b0, -1, -1, -1);
    check("frozen1_busy", int'(busy_start), 0);
    run_frame(8, 1, 1'b0, -1, -1, -1);
    check("frozen2_busy", int'(busy_start), 0);
    check("frozen_writes", wr_cnt - w0, 0);
    check("frozen_done", done_cnt - d0, 0);
    check("frozen_busy_end", int'(busy), 0);

    // reset in the middle of an active frame
    enable = 1'b1;
    wait_clk(4);
    w0 = wr_cnt; d0 = done_cnt;
    run_frame(8, 1, 1'b1, -1, -1, 3);
    check("rst_frame_writes", wr_cnt - w0, 8);
    check("rst_frame_done", done_cnt - d0, 0);
    w0 = wr_cnt; d0 = done_cnt;
    run_frame(3, 1, 1'b1, -1, -1, -1);
    check("recover_writes", wr_cnt - w0, 8);
    check("recover_done", done_cnt - d0, 1);

    wait_clk(10);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
